// File: rtl/ahb3lite_wait_slave_if.sv
// AHB3-Lite bus bundle for ahb3lite_wait_slave: master side drives the
// address/data phase and HREADY, slave side returns HRDATA/HREADYOUT/HRESP.
interface ahb3lite_wait_slave_if #(
  parameter int unsigned HADDR_SIZE = 16,
  parameter int unsigned HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
           HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
           HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb3lite_wait_slave.sv
// AHB3-Lite memory slave with programmable wait states, an address error
// window, two-cycle ERROR response, byte-lane writes and read-after-write
// forwarding. HBURST, HPROT and HMASTLOCK are accepted but not used.
module ahb3lite_wait_slave #(
  parameter int unsigned           HADDR_SIZE  = 16,
  parameter int unsigned           HDATA_SIZE  = 32,
  parameter int unsigned           MEM_DEPTH   = 256,
  parameter int unsigned           WAIT_STATES = 0,
  parameter logic [HADDR_SIZE-1:0] ERR_BASE    = 'h00F0,
  parameter logic [HADDR_SIZE-1:0] ERR_MASK    = 'hFFF0
) (
  input logic               HCLK,
  input logic               HRESETn,
  ahb3lite_wait_slave_if.slave bus
);

  localparam int unsigned BYTES    = HDATA_SIZE / 8;
  localparam int unsigned LSB      = $clog2(BYTES);
  localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic                  d_valid, d_valid_n;
  logic [HADDR_SIZE-1:0] d_addr, d_addr_n;
  logic                  d_write, d_write_n;
  logic [2:0]            d_size, d_size_n;
  logic [HDATA_SIZE-1:0] rdata, rdata_n;

  logic                  hready_o;
  logic                  accept;
  logic                  acc_err;
  logic                  wr_done;
  logic [BYTES-1:0]      wr_mask;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [HDATA_SIZE-1:0] fwd_word;

  logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

  function automatic logic [IDX_W-1:0] word_idx(input logic [HADDR_SIZE-1:0] a);
    logic [31:0] w;
    w = 32'(a) >> LSB;
    return w[IDX_W-1:0];
  endfunction

  function automatic logic [BYTES-1:0] lane_mask(input logic [HADDR_SIZE-1:0] a,
                                                 input logic [2:0] sz);
    logic [31:0]      off;
    logic [BYTES-1:0] m;
    off = 32'(a) & 32'(BYTES - 1);
    m   = '0;
    for (int unsigned i = 0; i < BYTES; i++) m[i] = ((i >> sz) == (off >> sz));
    return m;
  endfunction

  function automatic logic access_err(input logic [HADDR_SIZE-1:0] a,
                                      input logic [2:0] sz);
    logic win, bad_size, misalign;
    win      = (ERR_MASK != '0) && ((a & ERR_MASK) == ERR_BASE);
    bad_size = (32'(sz) > LSB);
    misalign = ((32'(a) & ((32'd1 << sz) - 32'd1)) != 32'd0);
    return win | bad_size | misalign;
  endfunction

  assign hready_o      = (state == IDLE) || (state == ERR2);
  assign bus.HREADYOUT = hready_o;
  assign bus.HRESP     = (state == ERR1) || (state == ERR2);
  assign bus.HRDATA    = rdata;

  // Address-phase decode and write-to-read forwarding of the completing write.
  always_comb begin
    accept   = bus.HSEL & bus.HREADY & bus.HTRANS[1] & hready_o;
    acc_err  = access_err(bus.HADDR, bus.HSIZE);
    wr_done  = d_valid && d_write && (state == IDLE);
    wr_mask  = lane_mask(d_addr, d_size);
    wr_idx   = word_idx(d_addr);
    rd_idx   = word_idx(bus.HADDR);
    fwd_word = mem[rd_idx];
    if (wr_done && (wr_idx == rd_idx)) begin
      for (int unsigned i = 0; i < BYTES; i++)
        if (wr_mask[i]) fwd_word[8*i +: 8] = bus.HWDATA[8*i +: 8];
    end
  end

  // Next-state, data-phase bookkeeping and read-data selection.
  // Read data is registered on the edge that opens the completing cycle, so a
  // zero-wait read needs the forwarded word from a write finishing that edge.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    d_valid_n = d_valid;
    d_addr_n  = d_addr;
    d_write_n = d_write;
    d_size_n  = d_size;
    rdata_n   = rdata;
    case (state)
      IDLE, ERR2: begin
        state_n   = IDLE;
        d_valid_n = 1'b0;
        if (accept) begin
          d_addr_n  = bus.HADDR;
          d_write_n = bus.HWRITE;
          d_size_n  = bus.HSIZE;
          if (acc_err) begin
            state_n = ERR1;
            if (!bus.HWRITE) rdata_n = '0;
          end else begin
            d_valid_n = 1'b1;
            if (WAIT_STATES == 0) begin
              if (!bus.HWRITE) rdata_n = fwd_word;
            end else begin
              state_n = WAIT;
              cnt_n   = CNT_LOAD;
            end
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_n = IDLE;
          if (!d_write) rdata_n = mem[wr_idx];
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      ERR1:    state_n = ERR2;
      default: state_n = IDLE;
    endcase
  end

  // State and data-phase registers; reset aborts any pending transfer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= IDLE;
      cnt     <= '0;
      d_valid <= 1'b0;
      d_addr  <= '0;
      d_write <= 1'b0;
      d_size  <= '0;
      rdata   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      d_valid <= d_valid_n;
      d_addr  <= d_addr_n;
      d_write <= d_write_n;
      d_size  <= d_size_n;
      rdata   <= rdata_n;
    end
  end

  // Byte-lane memory write on write completion.
  always_ff @(posedge HCLK) begin
    if (wr_done) begin
      for (int unsigned i = 0; i < BYTES; i++)
        if (wr_mask[i]) mem[wr_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_ahb3lite_wait_slave.sv
// Bench for ahb3lite_wait_slave: three instances (0, 3 and 5 wait states)
// driven by one pipelined AHB master task and checked against a byte-array
// transaction model.
module tb_ahb3lite_wait_slave;
  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned NB    = DEPTH * 4;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  int checks = 0;
  int failures = 0;

  int          tgt;
  logic        hsel_v;
  logic [15:0] haddr_v;
  logic [31:0] hwdata_v;
  logic        hwrite_v;
  logic [2:0]  hsize_v;
  logic [1:0]  htrans_v;
  logic [31:0] last_rd;

  ahb3lite_wait_slave_if #(.HADDR_SIZE(AW), .HDATA_SIZE(DW)) bus0 ();
  ahb3lite_wait_slave_if #(.HADDR_SIZE(AW), .HDATA_SIZE(DW)) bus1 ();
  ahb3lite_wait_slave_if #(.HADDR_SIZE(AW), .HDATA_SIZE(DW)) bus2 ();

  assign bus0.HSEL = hsel_v && (tgt == 0);
  assign bus1.HSEL = hsel_v && (tgt == 1);
  assign bus2.HSEL = hsel_v && (tgt == 2);
  assign bus0.HADDR = haddr_v;   assign bus1.HADDR = haddr_v;   assign bus2.HADDR = haddr_v;
  assign bus0.HWDATA = hwdata_v; assign bus1.HWDATA = hwdata_v; assign bus2.HWDATA = hwdata_v;
  assign bus0.HWRITE = hwrite_v; assign bus1.HWRITE = hwrite_v; assign bus2.HWRITE = hwrite_v;
  assign bus0.HSIZE = hsize_v;   assign bus1.HSIZE = hsize_v;   assign bus2.HSIZE = hsize_v;
  assign bus0.HTRANS = htrans_v; assign bus1.HTRANS = htrans_v; assign bus2.HTRANS = htrans_v;
  assign bus0.HBURST = 3'd0;     assign bus1.HBURST = 3'd1;     assign bus2.HBURST = 3'd0;
  assign bus0.HPROT = 4'd3;      assign bus1.HPROT = 4'd3;      assign bus2.HPROT = 4'd3;
  assign bus0.HMASTLOCK = 1'b0;  assign bus1.HMASTLOCK = 1'b0;  assign bus2.HMASTLOCK = 1'b0;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus1.HREADY = bus1.HREADYOUT;
  assign bus2.HREADY = bus2.HREADYOUT;

  ahb3lite_wait_slave #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .MEM_DEPTH(DEPTH), .WAIT_STATES(0))
    dut0 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0));
  ahb3lite_wait_slave #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .MEM_DEPTH(DEPTH), .WAIT_STATES(3))
    dut1 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus1));
  ahb3lite_wait_slave #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .MEM_DEPTH(DEPTH), .WAIT_STATES(5))
    dut2 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus2));

  logic        hro [3];
  logic        hresp_o [3];
  logic [31:0] hrd [3];
  assign hro[0] = bus0.HREADYOUT; assign hresp_o[0] = bus0.HRESP; assign hrd[0] = bus0.HRDATA;
  assign hro[1] = bus1.HREADYOUT; assign hresp_o[1] = bus1.HRESP; assign hrd[1] = bus1.HRDATA;
  assign hro[2] = bus2.HREADYOUT; assign hresp_o[2] = bus2.HRESP; assign hrd[2] = bus2.HRDATA;

  typedef struct {
    bit          hsel;
    logic [1:0]  trans;
    bit          write;
    logic [15:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } txn_t;

  txn_t q[$];
  logic [7:0] ref_mem [3][NB];

  function automatic int ws(input int k);
    return (k == 0) ? 0 : (k == 1) ? 3 : 5;
  endfunction

  function automatic bit m_err(input txn_t t);
    int a;
    int n;
    a = int'(t.addr);
    n = 1 << t.size;
    return ((a & 'hFFF0) == 'h00F0) || (t.size > 3'd2) || ((a % n) != 0);
  endfunction

  function automatic logic [31:0] m_word(input int k, input logic [15:0] a);
    int base;
    base = ((int'(a) / 4) * 4) % NB;
    return {ref_mem[k][base+3], ref_mem[k][base+2], ref_mem[k][base+1], ref_mem[k][base]};
  endfunction

  task automatic m_write(input int k, input txn_t t);
    int ba;
    for (int b = 0; b < (1 << t.size); b++) begin
      ba = int'(t.addr) + b;
      ref_mem[k][ba % NB] = t.wdata[8*(ba % 4) +: 8];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic add(input bit hs, input logic [1:0] tr, input bit wr,
                     input logic [15:0] a, input logic [2:0] sz, input logic [31:0] wd);
    txn_t t;
    t.hsel = hs; t.trans = tr; t.write = wr; t.addr = a; t.size = sz; t.wdata = wd;
    q.push_back(t);
  endtask

  // Pipelined master: presents the next address while the previous transfer is
  // in its data phase, advancing whenever HREADY is high. Entered at posedge+1.
  task automatic run_seq(input int k);
    int p = -1;
    int dp = -1;
    int nxt = 0;
    int done = 0;
    int lows = 0;
    int cyc = 0;
    int exp_lows;
    bit prev_ready = 1'b1;
    bit bad = 1'b0;
    bit ready, act, err;
    tgt = k;
    while (done < q.size()) begin
      if (prev_ready) begin
        dp = p;
        if (nxt < q.size()) begin p = nxt; nxt++; end
        else p = -1;
        lows = 0;
        bad = 1'b0;
      end
      if (p >= 0) begin
        hsel_v = q[p].hsel; htrans_v = q[p].trans; hwrite_v = q[p].write;
        haddr_v = q[p].addr; hsize_v = q[p].size;
      end else begin
        hsel_v = 1'b0; htrans_v = 2'd0; haddr_v = 16'($urandom);
      end
      hwdata_v = (dp >= 0) ? q[dp].wdata : $urandom;
      ready = hro[k];
      if (dp >= 0) begin
        act = q[dp].hsel && q[dp].trans[1];
        err = act && m_err(q[dp]);
        if (!ready) begin
          lows++;
          if (hresp_o[k] !== err) bad = 1'b1;
        end else begin
          exp_lows = !act ? 0 : (err ? 1 : ws(k));
          chk("wait_cycles", lows, exp_lows);
          chk("hresp", {31'd0, hresp_o[k]}, {31'd0, err});
          chk("resp_during_wait", {31'd0, bad}, 32'd0);
          if (act && !err && q[dp].write) m_write(k, q[dp]);
          if (act && !q[dp].write) begin
            chk("hrdata", hrd[k], err ? 32'd0 : m_word(k, q[dp].addr));
            last_rd = hrd[k];
          end
          done++;
        end
      end
      prev_ready = ready;
      @(posedge HCLK); #1;
      cyc++;
      if (cyc > 20 * q.size() + 20) begin
        checks++;
        failures++;
        $error("FAIL timeout: observed %0d cycles, expected completion of %0d transfers", cyc, q.size());
        break;
      end
    end
    hsel_v = 1'b0;
    htrans_v = 2'd0;
    q.delete();
  endtask

  initial begin
    tgt = 0; hsel_v = 1'b0; htrans_v = 2'd0; haddr_v = '0; hwdata_v = '0;
    hwrite_v = 1'b0; hsize_v = 3'd2; last_rd = '0;
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_hreadyout", {31'd0, hro[k]}, 32'd1);
      chk("rst_hresp", {31'd0, hresp_o[k]}, 32'd0);
      chk("rst_hrdata", hrd[k], 32'd0);
    end
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Give every instance a defined memory image.
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < int'(DEPTH); w++) add(1, 2'd2, 1, 16'(w * 4), 3'd2, 32'd0);
      run_seq(k);
    end

    // Zero-wait write then back-to-back read (forwarded).
    add(1, 2'd2, 1, 16'h0010, 3'd2, 32'hDEADBEEF);
    add(1, 2'd2, 0, 16'h0010, 3'd2, 32'h0);
    run_seq(0);
    chk("fwd_read", last_rd, 32'hDEADBEEF);

    // Byte-lane merge, read directly after the byte write.
    add(1, 2'd2, 1, 16'h0040, 3'd2, 32'h11223344);
    add(1, 2'd3, 1, 16'h0042, 3'd0, 32'h00AA0000);
    add(1, 2'd3, 0, 16'h0040, 3'd2, 32'h0);
    run_seq(0);
    chk("byte_lane", last_rd, 32'h11AA3344);

    // Three wait states on a read.
    add(1, 2'd2, 1, 16'h0020, 3'd2, 32'h600DF00D);
    add(1, 2'd2, 0, 16'h0020, 3'd2, 32'h0);
    run_seq(1);
    chk("ws3_read", last_rd, 32'h600DF00D);

    // Error window, oversize and misaligned accesses.
    add(1, 2'd2, 1, 16'h00F4, 3'd2, 32'h12121212);
    add(1, 2'd2, 0, 16'h00F4, 3'd2, 32'h0);
    add(1, 2'd2, 1, 16'h0008, 3'd3, 32'hFFFFFFFF);
    add(1, 2'd2, 1, 16'h000A, 3'd2, 32'hFFFFFFFF);
    add(1, 2'd2, 0, 16'h0008, 3'd2, 32'h0);
    run_seq(1);
    chk("err_no_write", last_rd, 32'h0);

    // Unselected, IDLE and BUSY transfers must be zero-wait with no effect.
    add(1, 2'd2, 1, 16'h0030, 3'd2, 32'h12345678);
    add(0, 2'd2, 1, 16'h0030, 3'd2, 32'hFFFFFFFF);
    add(1, 2'd0, 1, 16'h0030, 3'd2, 32'hFFFFFFFF);
    add(1, 2'd1, 1, 16'h0030, 3'd2, 32'hFFFFFFFF);
    add(1, 2'd2, 0, 16'h0030, 3'd2, 32'h0);
    run_seq(2);
    chk("idle_no_effect", last_rd, 32'h12345678);

    // Reset in the second wait cycle of a write.
    add(1, 2'd2, 1, 16'h0080, 3'd2, 32'hA5A55A5A);
    run_seq(1);
    tgt = 1; hsel_v = 1'b1; htrans_v = 2'd2; hwrite_v = 1'b1; haddr_v = 16'h0080; hsize_v = 3'd2;
    @(posedge HCLK); #1;
    hsel_v = 1'b0; htrans_v = 2'd0; hwdata_v = 32'hCAFEF00D;
    chk("rst_wait1", {31'd0, hro[1]}, 32'd0);
    @(posedge HCLK); #1;
    chk("rst_wait2", {31'd0, hro[1]}, 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    chk("rst_async_ready", {31'd0, hro[1]}, 32'd1);
    chk("rst_async_resp", {31'd0, hresp_o[1]}, 32'd0);
    chk("rst_async_rdata", hrd[1], 32'd0);
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK); #1;
    add(1, 2'd2, 0, 16'h0080, 3'd2, 32'h0);
    run_seq(1);
    chk("rst_write_dropped", last_rd, 32'hA5A55A5A);

    // Randomized traffic on every instance.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 60; i++) begin
        int unsigned r;
        logic [2:0]  sz;
        logic [15:0] a;
        logic [1:0]  tr;
        bit          hs;
        r  = $urandom_range(0, 99);
        sz = 3'($urandom_range(0, 2));
        a  = 16'($urandom_range(0, 16'h1FFF));
        a  = a & ~((16'd1 << sz) - 16'd1);
        hs = 1'b1;
        tr = 2'($urandom_range(2, 3));
        if (r < 10) begin
          a = 16'h00F0 | (a & 16'h000C); sz = 3'd2;
        end else if (r < 15) begin
          sz = 3'd3;
        end else if (r < 20) begin
          sz = 3'd2; a = a | 16'd1;
        end else if (r >= 95) begin
          tr = 2'($urandom_range(0, 1));
        end else if (r >= 90) begin
          hs = 1'b0;
        end
        add(hs, tr, bit'($urandom_range(0, 1)), a, sz, $urandom);
      end
      run_seq(k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
